// File: rtl/lcd_master_pkg.sv
// Shared types and constants for the character-LCD Avalon initiator.
// Holds the sequencer state encoding, HD44780 command bytes and LCD_IP register map.
package lcd_master_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_L1_CMD,
        S_L1_DATA,
        S_L2_CMD,
        S_L2_DATA,
        S_WGAP,
        S_POLL,
        S_PIDLE,
        S_RGAP,
        S_FINISH
    } state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic ADDR_INSTR = 1'b0;
    localparam logic ADDR_DATA  = 1'b1;

    localparam int         FB_DEPTH   = 32;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_buffer.sv
// 32-character frame store: synchronous write, combinational read, resets to spaces.
// Index 0-15 is line 1, 16-31 is line 2.
module lcd_frame_buffer
    import lcd_master_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [FB_DEPTH-1:0][7:0] mem_q;
    logic [FB_DEPTH-1:0][7:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= {FB_DEPTH{CHAR_SPACE}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_text_master.sv
// Avalon-MM initiator that pushes a two-line frame to LCD_IP, running HD44780 init once
// after reset and polling the busy flag after every write.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_INIT    | init instruction write (0x38, 0x0C, 0x01, 0x06)
// S_L1_CMD  | set DDRAM address to line 1
// S_L1_DATA | data write of chars 0-15
// S_L2_CMD  | set DDRAM address to line 2
// S_L2_DATA | data write of chars 16-31
// S_WGAP    | bus gap between a write and its first poll read
// S_POLL    | busy-flag read
// S_PIDLE   | idle cycle between busy reads
// S_RGAP    | bus gap between a finished poll and the next write
// S_FINISH  | done pulse, back to idle
module lcd_text_master
    import lcd_master_pkg::*;
#(
    parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fb_we,
    input  logic [4:0] fb_addr,
    input  logic [7:0] fb_char,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       address,
    output logic       chipselect,
    output logic       read,
    output logic       write,
    output logic [7:0] writedata,
    input  logic [7:0] readdata,
    input  logic       waitrequest
);

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic [3:0]  char_idx_q, char_idx_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        inited_q, inited_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        address_q, address_d;
    logic        cs_q, cs_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [4:0]  fb_raddr;
    logic [7:0]  fb_rdata;
    logic        unused_readdata;

    assign unused_readdata = ^readdata[6:0];

    lcd_frame_buffer u_fb (
        .clk   (clk),
        .reset (reset),
        .we    (fb_we),
        .waddr (fb_addr),
        .wdata (fb_char),
        .raddr (fb_raddr),
        .rdata (fb_rdata)
    );

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        init_idx_d = init_idx_q;
        char_idx_d = char_idx_q;
        poll_cnt_d = poll_cnt_q;
        inited_d   = inited_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    timeout_d  = 1'b0;
                    init_idx_d = 2'd0;
                    char_idx_d = 4'd0;
                    state_d    = inited_q ? S_L1_CMD : S_INIT;
                end
            end
            S_INIT: begin
                if (!waitrequest) begin
                    ret_d      = (init_idx_q == 2'd3) ? S_L1_CMD : S_INIT;
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = S_WGAP;
                end
            end
            S_L1_CMD: begin
                if (!waitrequest) begin
                    ret_d      = S_L1_DATA;
                    char_idx_d = 4'd0;
                    state_d    = S_WGAP;
                end
            end
            S_L1_DATA: begin
                if (!waitrequest) begin
                    ret_d      = (char_idx_q == 4'd15) ? S_L2_CMD : S_L1_DATA;
                    char_idx_d = char_idx_q + 4'd1;
                    state_d    = S_WGAP;
                end
            end
            S_L2_CMD: begin
                if (!waitrequest) begin
                    ret_d      = S_L2_DATA;
                    char_idx_d = 4'd0;
                    state_d    = S_WGAP;
                end
            end
            S_L2_DATA: begin
                if (!waitrequest) begin
                    ret_d      = (char_idx_q == 4'd15) ? S_FINISH : S_L2_DATA;
                    char_idx_d = char_idx_q + 4'd1;
                    state_d    = S_WGAP;
                end
            end
            S_WGAP: begin
                poll_cnt_d = POLL_LIMIT - 16'd1;
                state_d    = S_POLL;
            end
            S_POLL: begin
                // Down-counter reaching zero on a busy read means POLL_LIMIT busy reads seen.
                if (!waitrequest) begin
                    if (readdata[7]) begin
                        if (poll_cnt_q == 16'd0) begin
                            timeout_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            poll_cnt_d = poll_cnt_q - 16'd1;
                            state_d    = S_PIDLE;
                        end
                    end else begin
                        if (ret_q == S_L1_CMD) begin
                            inited_d = 1'b1;
                        end
                        state_d = (ret_q == S_FINISH) ? S_FINISH : S_RGAP;
                    end
                end
            end
            S_PIDLE:  state_d = S_POLL;
            S_RGAP:   state_d = ret_q;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign fb_raddr = {state_d == S_L2_DATA, char_idx_d};

    // Bus outputs are registered from the next state; data is latched only on state entry
    // so it holds through waitrequest and a same-cycle fb_we sends the old character.
    always_comb begin
        cs_d      = 1'b0;
        read_d    = 1'b0;
        write_d   = 1'b0;
        address_d = address_q;
        wdata_d   = wdata_q;
        busy_d    = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d    = (state_d == S_FINISH);
        if (state_d != state_q) begin
            case (state_d)
                S_INIT: begin
                    address_d = ADDR_INSTR;
                    wdata_d   = init_cmd(init_idx_d);
                end
                S_L1_CMD: begin
                    address_d = ADDR_INSTR;
                    wdata_d   = LCD_LINE1;
                end
                S_L2_CMD: begin
                    address_d = ADDR_INSTR;
                    wdata_d   = LCD_LINE2;
                end
                S_L1_DATA, S_L2_DATA: begin
                    address_d = ADDR_DATA;
                    wdata_d   = fb_rdata;
                end
                S_POLL:  address_d = ADDR_INSTR;
                default: ;
            endcase
        end
        case (state_d)
            S_INIT, S_L1_CMD, S_L1_DATA, S_L2_CMD, S_L2_DATA: begin
                cs_d    = 1'b1;
                write_d = 1'b1;
            end
            S_POLL: begin
                cs_d   = 1'b1;
                read_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            init_idx_q <= 2'd0;
            char_idx_q <= 4'd0;
            poll_cnt_q <= 16'd0;
            inited_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            address_q  <= 1'b0;
            cs_q       <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            init_idx_q <= init_idx_d;
            char_idx_q <= char_idx_d;
            poll_cnt_q <= poll_cnt_d;
            inited_q   <= inited_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            address_q  <= address_d;
            cs_q       <= cs_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign address     = address_q;
    assign chipselect  = cs_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = wdata_q;

endmodule

// File: tb/tb_lcd_text_master.sv
// Bench for lcd_text_master: an LCD_IP slave model with configurable wait/busy behaviour
// logs every transfer, and each scenario compares the log against a frame-level model.
module tb_lcd_text_master;

    logic       clk = 1'b0;
    logic       reset, start, fb_we;
    logic [4:0] fb_addr;
    logic [7:0] fb_char;
    logic       busy, done, timeout_err;
    logic       address, chipselect, read, write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    lcd_text_master #(.POLL_LIMIT(16'd4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_char     (fb_char),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [7:0] model_frame [32];
    bit         model_inited;
    logic [8:0] exp_q[$];
    logic [8:0] wlog_q[$];
    int         rlog_q[$];
    int         erp_q[$];

    int cfg_wait_write, cfg_wait_len, cfg_busy_write, cfg_busy_n;
    bit cfg_rand, cfg_stuck;

    int   wr_count, wait_obs, done_cnt, viol_proto, viol_stab, viol_gap;
    int   wait_left, busy_left;
    bit   in_xfer, prev_cmp, prev2_cmp, mon_cmp;
    logic cap_addr, cap_rd, cap_wr;
    logic [7:0] cap_wd;

    // LCD_IP slave model: decides waitrequest/readdata each cycle and logs completions.
    initial begin
        waitrequest = 1'b0;
        readdata    = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_xfer = 0; waitrequest = 1'b0; readdata = 8'h00;
                prev_cmp = 0; prev2_cmp = 0; wait_left = 0; busy_left = 0;
            end else begin
                mon_cmp = 0;
                if (read && write) viol_proto++;
                if (done && busy) viol_proto++;
                if (done) done_cnt++;
                if (in_xfer && (address !== cap_addr || writedata !== cap_wd ||
                                read !== cap_rd || write !== cap_wr || chipselect !== 1'b1))
                    viol_stab++;
                if (prev_cmp && chipselect) viol_gap++;
                if (prev2_cmp && !prev_cmp && busy && !chipselect) viol_gap++;
                if (chipselect && !in_xfer) begin
                    in_xfer = 1;
                    cap_addr = address; cap_wd = writedata; cap_rd = read; cap_wr = write;
                    if (write)
                        wait_left = (wr_count == cfg_wait_write) ? cfg_wait_len :
                                    (cfg_rand ? int'($urandom_range(0, 2)) : 0);
                    else
                        wait_left = cfg_rand ? int'($urandom_range(0, 2)) : 0;
                end
                if (chipselect) begin
                    if (wait_left > 0) begin
                        waitrequest = 1'b1;
                        wait_left--;
                        if (write) wait_obs++;
                    end else begin
                        waitrequest = 1'b0;
                        mon_cmp = 1;
                        in_xfer = 0;
                        if (write) begin
                            busy_left = (wr_count == cfg_busy_write) ? cfg_busy_n :
                                        (cfg_rand ? int'($urandom_range(0, 3)) : 0);
                            wlog_q.push_back({address, writedata});
                            rlog_q.push_back(0);
                            erp_q.push_back(busy_left + 1);
                            wr_count++;
                            readdata = 8'h00;
                        end else begin
                            if (rlog_q.size() > 0) rlog_q[rlog_q.size()-1]++;
                            if (cfg_stuck || busy_left > 0) begin
                                readdata = 8'h80 | 8'($urandom_range(0, 127));
                                if (busy_left > 0) busy_left--;
                            end else begin
                                readdata = 8'($urandom_range(0, 127));
                            end
                        end
                    end
                end else begin
                    waitrequest = 1'b0;
                end
                prev2_cmp = prev_cmp;
                prev_cmp  = mon_cmp;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_cfg();
        cfg_wait_write = -1; cfg_wait_len = 0; cfg_busy_write = -1; cfg_busy_n = 0;
        cfg_rand = 0; cfg_stuck = 0;
    endtask

    task automatic clear_logs();
        wlog_q.delete(); rlog_q.delete(); erp_q.delete(); exp_q.delete();
        wr_count = 0; wait_obs = 0; done_cnt = 0;
        viol_proto = 0; viol_stab = 0; viol_gap = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_frame[i] = 8'h20;
        model_inited = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; fb_we = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic fb_write(input logic [4:0] a, input logic [7:0] c);
        fb_we = 1'b1; fb_addr = a; fb_char = c;
        @(posedge clk);
        #2 fb_we = 1'b0;
        model_frame[a] = c;
    endtask

    // Expected write stream derived directly from the display rules.
    task automatic build_exp(input bit with_init);
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
            exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h06});
        end
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model_frame[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, model_frame[i]});
    endtask

    task automatic start_refresh(input bit with_init);
        logic [7:0] first_cmd;
        first_cmd = with_init ? 8'h38 : 8'h80;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        vectors++;
        if ({busy, chipselect, write, read} !== 4'b1110) begin
            miscompares++;
            $display("FAIL start_latency: got busy/cs/wr/rd=%b required 1110", {busy, chipselect, write, read});
        end
        vectors++;
        if (writedata !== first_cmd) begin
            miscompares++;
            $display("FAIL first_writedata: got %02h required %02h", writedata, first_cmd);
        end
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear_on_start: got %b required 0", timeout_err);
        end
    endtask

    task automatic wait_done(output bit finished);
        bit ended;
        finished = 0;
        ended = 0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                finished = 1;
                start = 1'b1;
                @(posedge clk);
                #2 start = 1'b0;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL start_on_done_ignored: got busy=%b required 0", busy);
                end
                ended = 1;
                break;
            end
            if (timeout_err && !busy) begin
                ended = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        vectors++;
        if (!ended) begin
            miscompares++;
            $display("FAIL refresh_bound: got still busy after 5000 cycles required termination");
        end
    endtask

    task automatic check_refresh(input string name, input bit finished);
        bit first;
        int n;
        vectors++;
        if (finished !== 1'b1 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s_done: got finished=%0d done_pulses=%0d required 1 and 1", name, finished, done_cnt);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_end: got %b required 0", name, busy);
        end
        vectors++;
        if (wlog_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d required %0d", name, wlog_q.size(), exp_q.size());
        end
        n = (wlog_q.size() < exp_q.size()) ? wlog_q.size() : exp_q.size();
        first = 1;
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (wlog_q[i] !== exp_q[i]) begin
                miscompares++;
                if (first) $display("FAIL %s_write[%0d]: got addr/data %03h required %03h", name, i, wlog_q[i], exp_q[i]);
                first = 0;
            end
        end
        first = 1;
        for (int i = 0; i < rlog_q.size(); i++) begin
            vectors++;
            if (rlog_q[i] !== erp_q[i]) begin
                miscompares++;
                if (first) $display("FAIL %s_reads[%0d]: got %0d reads required %0d", name, i, rlog_q[i], erp_q[i]);
                first = 0;
            end
        end
        vectors++;
        if (viol_proto + viol_stab + viol_gap != 0) begin
            miscompares++;
            $display("FAIL %s_protocol: got proto=%0d stable=%0d gap=%0d required all 0", name, viol_proto, viol_stab, viol_gap);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({busy, done, timeout_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got busy/done/tmo=%b required 000", {busy, done, timeout_err});
        end
        vectors++;
        if ({chipselect, read, write, address} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got cs/rd/wr/addr=%b required 0000", {chipselect, read, write, address});
        end
        vectors++;
        if (writedata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_writedata: got %02h required 00", writedata);
        end
    endtask

    task automatic test_first_refresh();
        bit f;
        clear_cfg(); clear_logs();
        start_refresh(1);
        wait_done(f);
        build_exp(1);
        check_refresh("first", f);
        model_inited = 1;
    endtask

    task automatic test_hello_world();
        bit f;
        logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        logic [7:0] world [5] = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
        for (int i = 0; i < 5; i++) fb_write(5'(i), hello[i]);
        for (int i = 0; i < 5; i++) fb_write(5'(16 + i), world[i]);
        clear_cfg(); clear_logs();
        start_refresh(0);
        wait_done(f);
        vectors++;
        if (wlog_q.size() < 2 || wlog_q[1] !== 9'h148) begin
            miscompares++;
            $display("FAIL hello_first_char: got %03h required 148", wlog_q.size() > 1 ? wlog_q[1] : 9'h000);
        end
        build_exp(0);
        check_refresh("hello", f);
    endtask

    task automatic test_waitrequest();
        bit f;
        clear_cfg(); clear_logs();
        cfg_wait_write = 2; cfg_wait_len = 5;
        start_refresh(0);
        wait_done(f);
        vectors++;
        if (wait_obs !== 5) begin
            miscompares++;
            $display("FAIL wait_cycles: got %0d required 5", wait_obs);
        end
        build_exp(0);
        check_refresh("waitreq", f);
        clear_cfg();
    endtask

    task automatic test_fb_during_refresh();
        bit f;
        logic [7:0] old0, new0, new16;
        clear_cfg(); clear_logs();
        start_refresh(0);
        for (int i = 0; i < 500 && wr_count < 3; i++) begin
            @(posedge clk);
            #2;
        end
        old0  = model_frame[0];
        new0  = (old0 == 8'h7E) ? 8'h21 : old0 + 8'd1;
        new16 = 8'($urandom_range(33, 126));
        fb_write(5'd0, new0);
        fb_write(5'd16, new16);
        wait_done(f);
        build_exp(0);
        exp_q[1] = {1'b1, old0};
        check_refresh("late_write", f);
        clear_logs();
        start_refresh(0);
        wait_done(f);
        build_exp(0);
        check_refresh("late_write_next", f);
    endtask

    task automatic test_busy_poll();
        bit f;
        apply_reset();
        clear_cfg(); clear_logs();
        cfg_busy_write = 2; cfg_busy_n = 3;
        start_refresh(1);
        wait_done(f);
        vectors++;
        if (rlog_q.size() < 3 || rlog_q[2] !== 4) begin
            miscompares++;
            $display("FAIL busy_poll_reads: got %0d required 4", rlog_q.size() > 2 ? rlog_q[2] : -1);
        end
        build_exp(1);
        check_refresh("busy_poll", f);
        model_inited = 1;
        clear_cfg();
    endtask

    task automatic test_timeout();
        bit f;
        apply_reset();
        clear_cfg(); clear_logs();
        cfg_stuck = 1;
        start_refresh(1);
        wait_done(f);
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (wr_count !== 1 || rlog_q.size() != 1 || rlog_q[0] !== 4) begin
            miscompares++;
            $display("FAIL timeout_reads: got writes=%0d reads=%0d required 1 and 4", wr_count, rlog_q.size() > 0 ? rlog_q[0] : -1);
        end
        vectors++;
        if ({timeout_err, busy, done} !== 3'b100 || done_cnt !== 0) begin
            miscompares++;
            $display("FAIL timeout_status: got tmo/busy/done=%b pulses=%0d required 100 and 0", {timeout_err, busy, done}, done_cnt);
        end
        clear_cfg(); clear_logs();
        start_refresh(1);
        wait_done(f);
        build_exp(1);
        check_refresh("after_timeout", f);
        model_inited = 1;
    endtask

    task automatic test_reset_mid();
        bit f;
        bit found;
        apply_reset();
        fb_write(5'd7, 8'($urandom_range(33, 126)));
        clear_cfg(); clear_logs();
        cfg_wait_write = 12; cfg_wait_len = 1000;
        start_refresh(1);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (wr_count == 12 && chipselect && write) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        vectors++;
        if (!found || address !== 1'b1 || writedata !== model_frame[7]) begin
            miscompares++;
            $display("FAIL mid_index7: got found=%0d addr=%b data=%02h required 1,1,%02h", found, address, writedata, model_frame[7]);
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        vectors++;
        if ({chipselect, read, write, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_strobes: got cs/rd/wr/busy=%b required 0000", {chipselect, read, write, busy});
        end
        reset = 1'b0;
        model_reset();
        clear_cfg(); clear_logs();
        start_refresh(1);
        wait_done(f);
        build_exp(1);
        check_refresh("after_mid_reset", f);
        model_inited = 1;
    endtask

    task automatic test_random();
        bit f;
        bit w;
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(3, 10))
                fb_write(5'($urandom_range(0, 31)), 8'($urandom_range(32, 126)));
            clear_cfg(); clear_logs();
            cfg_rand = 1;
            w = !model_inited;
            start_refresh(w);
            wait_done(f);
            build_exp(w);
            check_refresh("random", f);
            if (f) model_inited = 1;
        end
        clear_cfg();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        start = 1'b0; fb_we = 1'b0; fb_addr = 5'd0; fb_char = 8'h00; reset = 1'b1;
        clear_cfg();
        clear_logs();
        test_reset();
        test_first_refresh();
        test_hello_world();
        test_waitrequest();
        test_fb_during_refresh();
        test_busy_poll();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
